// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants for the 4-way round-robin arbiter.
// FSM state encodings and default hold-timeout sizing.
package mux4_rr_arbiter_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  localparam int MAX_HOLD_DEF = 16;
  localparam int CNT_BITS_DEF = 5;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requester after last owner.
// Ports: req[3:0], last[1:0] in; winner[1:0], valid out.
module rr_priority_pick
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       valid
);

  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] off;

  // rot[0] is the requester right after the last owner
  assign dbl = {req, req};
  assign rot = dbl[{1'b0, last} + 3'd1 +: 4];

  always_comb begin
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
  end

  assign winner = last + 2'd1 + off;
  assign valid  = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with hold timeout driving a 4:1 mux Selector.
// Ports: clk, reset(n) | Req[3:0], Done in | Grant, Selector, Busy, Timeout out.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MaxHold = MAX_HOLD_DEF,
  parameter int CntBits = CNT_BITS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Req,
  input  logic       Done,
  output logic [3:0] Grant,
  output logic [1:0] Selector,
  output logic       Busy,
  output logic       Timeout
);

  logic [0:0]         state;
  logic [CntBits-1:0] cnt;
  logic [1:0]         last;
  logic [1:0]         win;
  logic               win_vld;
  logic               rel_b;
  logic               rel_c;
  logic               rel;

  rr_priority_pick u_pick (
    .req    (Req),
    .last   (last),
    .winner (win),
    .valid  (win_vld)
  );

  assign rel_b = ~Req[Selector];
  assign rel_c = (MaxHold != 0) &&
                 (cnt == CntBits'(MaxHold - 1));
  assign rel   = Done | rel_b | rel_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 2'd3;
      Grant    <= 4'b0000;
      Selector <= 2'd0;
      Busy     <= 1'b0;
      Timeout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          Timeout <= 1'b0;
          if (win_vld) begin
            state    <= OWN;
            Grant    <= 4'b0001 << win;
            Selector <= win;
            Busy     <= 1'b1;
            cnt      <= '0;
          end
        end
        OWN: begin
          if (rel) begin
            state   <= IDLE;
            Grant   <= 4'b0000;
            Busy    <= 1'b0;
            last    <= Selector;
            // forced release only when nothing else ended it
            Timeout <= rel_c & ~Done & ~rel_b;
          end else begin
            Timeout <= 1'b0;
            if (cnt != CntBits'(MaxHold))
              cnt <= cnt + CntBits'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: three hold settings, one shared stimulus.
// Reference model tracks owner/history per instance at cycle level.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] Req = 4'b0;
  logic       Done = 1'b0;

  logic [2:0][3:0] g;
  logic [2:0][1:0] s;
  logic [2:0]      b;
  logic [2:0]      t;

  int nvec = 0;
  int nbad = 0;

  int mh[3] = '{16, 4, 0};
  bit own[3];
  int sel[3];
  int last[3];
  int held[3];
  bit to[3];

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MaxHold(16), .CntBits(5)) u16 (
    .clk(clk), .reset(reset), .Req(Req), .Done(Done),
    .Grant(g[0]), .Selector(s[0]), .Busy(b[0]), .Timeout(t[0]));
  mux4_rr_arbiter #(.MaxHold(4), .CntBits(3)) u4 (
    .clk(clk), .reset(reset), .Req(Req), .Done(Done),
    .Grant(g[1]), .Selector(s[1]), .Busy(b[1]), .Timeout(t[1]));
  mux4_rr_arbiter #(.MaxHold(0), .CntBits(2)) u0 (
    .clk(clk), .reset(reset), .Req(Req), .Done(Done),
    .Grant(g[2]), .Selector(s[2]), .Busy(b[2]), .Timeout(t[2]));

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      own[k] = 0; sel[k] = 0; last[k] = 3;
      held[k] = 0; to[k] = 0;
    end
  endtask

  task automatic model_step(logic [3:0] r, logic d);
    for (int k = 0; k < 3; k++) begin
      if (!own[k]) begin
        to[k] = 0;
        if (r != 0) begin
          for (int j = 1; j <= 4; j++) begin
            int i;
            i = (last[k] + j) % 4;
            if (!own[k] && r[i]) begin
              own[k] = 1; sel[k] = i; held[k] = 1;
            end
          end
        end
      end else begin
        bit ra, rb, rc;
        ra = d;
        rb = !r[sel[k]];
        rc = (mh[k] != 0) && (held[k] == mh[k]);
        if (ra || rb || rc) begin
          own[k] = 0; last[k] = sel[k];
          to[k] = rc && !ra && !rb;
        end else begin
          held[k]++;
          to[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] eg;
      eg = own[k] ? (4'b0001 << sel[k]) : 4'b0000;
      chk($sformatf("%s/grant%0d", tag, k), g[k], eg);
      chk($sformatf("%s/sel%0d", tag, k), {2'b00, s[k]}, 4'(sel[k]));
      chk($sformatf("%s/busy%0d", tag, k), {3'b000, b[k]}, {3'b000, own[k]});
      chk($sformatf("%s/tmo%0d", tag, k), {3'b000, t[k]}, {3'b000, to[k]});
    end
  endtask

  task automatic step(logic [3:0] r, logic d, string tag);
    Req = r;
    Done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    int hc;
    int tc;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b1;
    #1;

    // rotation under full load, Done one cycle after each grant
    for (int i = 0; i < 5; i++) begin
      step(4'hf, 1'b0, "rot_g");
      chk("rot_seq", g[0], 4'b0001 << (i % 4));
      chk("rot_selseq", {2'b00, s[0]}, 4'(i % 4));
      step(4'hf, 1'b1, "rot_r");
      chk("rot_idle", g[0], 4'b0000);
    end

    // lone requester 2 runs into the 16-cycle timeout
    step(4'h0, 1'b0, "drain");
    step(4'h0, 1'b0, "drain");
    hc = 0; tc = 0;
    for (int i = 0; i < 17; i++) begin
      step(4'b0100, 1'b0, "tmo");
      if (g[0] == 4'b0100) hc++;
      if (t[0]) tc++;
    end
    chk("tmo_hold", 4'(hc), 4'(16 % 16));
    chk("tmo_hold_hi", {3'b0, hc == 16}, 4'd1);
    chk("tmo_pulses", 4'(tc), 4'd1);
    step(4'b0100, 1'b0, "tmo_regrant");
    chk("tmo_regrant", g[0], 4'b0100);

    // owner 1 drops its request after 3 cycles
    step(4'h0, 1'b0, "drain");
    step(4'h0, 1'b0, "drain");
    step(4'b0010, 1'b0, "drop");
    step(4'b0010, 1'b0, "drop");
    step(4'b0010, 1'b0, "drop");
    step(4'b1101, 1'b0, "drop_rel");
    chk("drop_busy", {3'b0, b[0]}, 4'd0);
    chk("drop_tmo", {3'b0, t[0]}, 4'd0);
    step(4'b1101, 1'b0, "drop_next");
    chk("drop_next", g[0], 4'b0100);

    // Done coincides with the timeout cycle on MaxHold=4
    step(4'h0, 1'b0, "drain");
    step(4'h0, 1'b0, "drain");
    step(4'b1000, 1'b0, "both");
    for (int i = 0; i < 3; i++) step(4'b1000, 1'b0, "both");
    step(4'b1000, 1'b1, "both_rel");
    chk("both_busy", {3'b0, b[1]}, 4'd0);
    chk("both_tmo", {3'b0, t[1]}, 4'd0);

    // asynchronous reset in the middle of a grant
    step(4'hf, 1'b0, "ar");
    step(4'hf, 1'b0, "ar");
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 reset = 1'b1;
    step(4'b1010, 1'b0, "ar_first");
    chk("ar_first", g[0], 4'b0010);

    // timeout disabled: owner 0 held indefinitely
    step(4'h0, 1'b0, "drain");
    step(4'h0, 1'b0, "drain");
    hc = 0; tc = 0;
    for (int i = 0; i < 100; i++) begin
      step(4'b0001, 1'b0, "nohold");
      if (g[2] == 4'b0001) hc++;
      if (t[2]) tc++;
    end
    chk("nohold_cnt", {3'b0, hc == 100}, 4'd1);
    chk("nohold_tmo", 4'(tc), 4'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
